// File: rtl/bias_pkg.sv
// bias_pkg: shared constants and arithmetic helpers for the bias-add bank.
package bias_pkg;
  localparam int DEF_DW = 18;
  localparam int MAXW = 64;
  typedef logic signed [MAXW-1:0] wide_t;
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction
  // Returns {ovf, result}; wrap mode callers keep only the low w bits of result.
  function automatic logic [MAXW:0] sat_add(input wide_t a, input wide_t b, input int w, input logic sat);
    wide_t s, hi, lo;
    logic ovf;
    s = a + b;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    ovf = (s > hi) || (s < lo);
    return {ovf, (sat && s > hi) ? hi : (sat && s < lo) ? lo : s};
  endfunction
endpackage

// File: rtl/bias_regfile.sv
// bias_regfile: DEPTH x N_LANES bias words, one lane write port, one full-vector read port.
module bias_regfile import bias_pkg::*; #(
  parameter int N_LANES = 16,
  parameter int DW = DEF_DW,
  parameter int DEPTH = 4,
  parameter int GW = 2,
  parameter int LW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [GW-1:0]          wgroup,
  input  logic [LW-1:0]          wlane,
  input  logic [DW-1:0]          wdata,
  input  logic [GW-1:0]          rgroup,
  output logic [N_LANES*DW-1:0]  rdata
);
  logic [N_LANES*DW-1:0] mem [DEPTH];
  // Writes to groups >= DEPTH match no row and fall away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < DEPTH; g++) mem[g] <= '0;
    end else begin
      for (int g = 0; g < DEPTH; g++)
        for (int l = 0; l < N_LANES; l++)
          if (we && wgroup == GW'(g) && wlane == LW'(l)) mem[g][lane_lsb(l, DW) +: DW] <= wdata;
    end
  end
  assign rdata = (32'(rgroup) < DEPTH) ? mem[rgroup] : '0;
endmodule

// File: rtl/bias_add_bank.sv
// bias_add_bank: adds a runtime-loaded per-group bias vector to accumulator vectors
// through a two-stage valid/ready pipeline with optional saturation.
module bias_add_bank import bias_pkg::*; #(
  parameter int N_LANES = 16,
  parameter int DW = DEF_DW,
  parameter int DEPTH = 4,
  parameter int SAT_EN = 1,
  parameter int GW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_en,
  input  logic [GW-1:0]         ld_group,
  input  logic [LW-1:0]         ld_lane,
  input  logic [DW-1:0]         ld_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [GW-1:0]         in_group,
  input  logic                  in_bias_en,
  input  logic [N_LANES*DW-1:0] in_acc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_LANES*DW-1:0] out_data,
  output logic [N_LANES-1:0]    out_sat,
  output logic                  out_err
);
  logic [N_LANES*DW-1:0] rd_bias, s1_acc, s1_bias, nxt_data;
  logic [N_LANES-1:0] nxt_sat;
  logic [MAXW:0] r;
  logic s1_valid, s1_err, s2_adv, grp_err;
  bias_regfile #(.N_LANES(N_LANES), .DW(DW), .DEPTH(DEPTH), .GW(GW), .LW(LW)) u_rf (
    .clk(clk), .rst_n(rst_n), .we(ld_en), .wgroup(ld_group), .wlane(ld_lane),
    .wdata(ld_data), .rgroup(in_group), .rdata(rd_bias)
  );
  assign grp_err = 32'(in_group) >= DEPTH;
  assign s2_adv = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  // A disabled or out-of-range bias is zeroed at capture, so it can never flag overflow.
  always_comb begin
    nxt_data = '0;
    nxt_sat = '0;
    r = '0;
    for (int i = 0; i < N_LANES; i++) begin
      r = sat_add(wide_t'($signed(s1_acc[lane_lsb(i, DW) +: DW])),
                  wide_t'($signed(s1_bias[lane_lsb(i, DW) +: DW])), DW, SAT_EN != 0);
      nxt_data[lane_lsb(i, DW) +: DW] = r[DW-1:0];
      nxt_sat[i] = r[MAXW];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err <= 1'b0;
      s1_acc <= '0;
      s1_bias <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= '0;
      out_err <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_acc <= in_acc;
        s1_bias <= (in_bias_en && !grp_err) ? rd_bias : '0;
        s1_err <= grp_err;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= nxt_data;
          out_sat <= nxt_sat;
          out_err <= s1_err;
        end
      end
    end
  end
endmodule

// File: tb/tb_bias_add_bank.sv
// tb_bias_add_bank: saturating and wrapping instances driven in lockstep and
// checked against a queue-based arithmetic model.
module tb_bias_add_bank;
  localparam int NL = 16, DW = 18, DEP = 3, W = NL * DW;
  localparam int MAXV = 2 ** (DW - 1) - 1, MINV = -(2 ** (DW - 1));
  logic clk = 1'b0, rst_n = 1'b0;
  logic ld_en, in_valid, in_bias_en, out_ready;
  logic [1:0] ld_group, in_group;
  logic [3:0] ld_lane;
  logic [DW-1:0] ld_data;
  logic [W-1:0] in_acc, d_s, d_w;
  logic rdy_s, rdy_w, ov_s, ov_w, err_s, err_w;
  logic [NL-1:0] sat_s, sat_w;
  always #5 clk = ~clk;

  bias_add_bank #(.N_LANES(NL), .DW(DW), .DEPTH(DEP), .SAT_EN(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_group(ld_group), .ld_lane(ld_lane),
    .ld_data(ld_data), .in_valid(in_valid), .in_ready(rdy_s), .in_group(in_group),
    .in_bias_en(in_bias_en), .in_acc(in_acc), .out_valid(ov_s), .out_ready(out_ready),
    .out_data(d_s), .out_sat(sat_s), .out_err(err_s)
  );
  bias_add_bank #(.N_LANES(NL), .DW(DW), .DEPTH(DEP), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_group(ld_group), .ld_lane(ld_lane),
    .ld_data(ld_data), .in_valid(in_valid), .in_ready(rdy_w), .in_group(in_group),
    .in_bias_en(in_bias_en), .in_acc(in_acc), .out_valid(ov_w), .out_ready(out_ready),
    .out_data(d_w), .out_sat(sat_w), .out_err(err_w)
  );

  typedef struct { logic [W-1:0] ds, dw; logic [NL-1:0] f; logic e; } exp_t;
  typedef struct { logic [DW-1:0] acc; int lane; int grp; bit en; logic [DW-1:0] es, ew; bit ef, ee; } vec_t;
  int bias [DEP][NL];
  exp_t q[$];
  exp_t obs[$];
  int n_chk = 0, n_fail = 0;
  logic held = 1'b0, hold_e;
  logic [W-1:0] hold_s, hold_w;
  logic [NL-1:0] hold_f;
  bit busy;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] acc, input int g, input bit en);
    exp_t r;
    int a, b, s;
    logic signed [DW-1:0] t;
    r.e = g >= DEP;
    r.f = '0;
    r.ds = '0;
    r.dw = '0;
    for (int i = 0; i < NL; i++) begin
      t = acc[i*DW +: DW];
      a = t;
      b = 0;
      if (en && !r.e) b = bias[g][i];
      s = a + b;
      r.f[i] = s > MAXV || s < MINV;
      r.dw[i*DW +: DW] = s[DW-1:0];
      r.ds[i*DW +: DW] = s > MAXV ? DW'(MAXV) : s < MINV ? DW'(MINV) : s[DW-1:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e, o;
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
      for (int g = 0; g < DEP; g++) for (int i = 0; i < NL; i++) bias[g][i] = 0;
    end else begin
      if (held && ov_s) begin
        chk("hold_data", d_s, hold_s);
        chk("hold_wrap", d_w, hold_w);
        chk("hold_sat", W'(sat_s), W'(hold_f));
        chk("hold_err", W'(err_s), W'(hold_e));
      end
      chk("in_ready", W'({rdy_s, rdy_w}), W'({2{!(q.size() == 2 && !out_ready)}}));
      if (q.size() == 0) chk("idle_valid", W'({ov_s, ov_w}), W'(0));
      if (ov_s && out_ready) begin
        if (q.size() == 0) chk("spurious_out", W'(1), W'(0));
        else begin
          e = q.pop_front();
          chk("valid_wrap", W'(ov_w), W'(1));
          chk("data_sat", d_s, e.ds);
          chk("data_wrap", d_w, e.dw);
          chk("flag_sat", W'(sat_s), W'(e.f));
          chk("flag_wrap", W'(sat_w), W'(e.f));
          chk("err", W'({err_s, err_w}), W'({2{e.e}}));
        end
        o.ds = d_s;
        o.dw = d_w;
        o.f = sat_s;
        o.e = err_s;
        obs.push_back(o);
      end
      held = ov_s && !out_ready;
      hold_s = d_s;
      hold_w = d_w;
      hold_f = sat_s;
      hold_e = err_s;
      if (in_valid && rdy_s) q.push_back(model(in_acc, int'(in_group), in_bias_en));
      if (ld_en && int'(ld_group) < DEP) bias[int'(ld_group)][int'(ld_lane)] = int'($signed(ld_data));
    end
  end

  task automatic load(input int g, input int l, input int v);
    ld_en = 1'b1;
    ld_group = 2'(g);
    ld_lane = 4'(l);
    ld_data = DW'(v);
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] acc, input int g, input bit en, input bit drop);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_acc = acc;
    in_group = 2'(g);
    in_bias_en = en;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = rdy_s;
    end
    if (!ok) chk("accept_timeout", W'(0), W'(1));
    @(posedge clk);
    #1 if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) chk("drain_timeout", W'(q.size()), W'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[10];
    logic [W-1:0] acc;
    exp_t o;
    int n0;
    tv[0] = '{DW'(1000), 0, 0, 1'b1, DW'(608), DW'(608), 1'b0, 1'b0};
    tv[1] = '{DW'(131000), 3, 0, 1'b1, DW'(131071), DW'(-130944), 1'b1, 1'b0};
    tv[2] = '{DW'(-131000), 0, 0, 1'b1, DW'(-131072), DW'(130752), 1'b1, 1'b0};
    tv[3] = '{DW'(131000), 3, 0, 1'b0, DW'(131000), DW'(131000), 1'b0, 1'b0};
    tv[4] = '{DW'(1000), 0, 3, 1'b1, DW'(1000), DW'(1000), 1'b0, 1'b1};
    tv[5] = '{DW'(-5), 5, 1, 1'b1, DW'(72), DW'(72), 1'b0, 1'b0};
    tv[6] = '{DW'(-131072), 3, 2, 1'b1, DW'(-131072), DW'(131071), 1'b1, 1'b0};
    tv[7] = '{DW'(131071), 15, 2, 1'b1, DW'(131071), DW'(131071), 1'b0, 1'b0};
    tv[8] = '{DW'(0), 3, 0, 1'b1, DW'(200), DW'(200), 1'b0, 1'b0};
    tv[9] = '{DW'(7), 3, 3, 1'b1, DW'(7), DW'(7), 1'b0, 1'b1};
    ld_en = 0; ld_group = 0; ld_lane = 0; ld_data = 0;
    in_valid = 0; in_group = 0; in_bias_en = 0; in_acc = '0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", W'({ov_s, ov_w}), W'(0));
    chk("rst_ready", W'({rdy_s, rdy_w}), W'(2'b11));
    chk("rst_data", d_s | d_w, W'(0));
    chk("rst_flags", W'({sat_s, sat_w, err_s, err_w}), W'(0));
    rst_n = 1'b1;
    load(0, 0, -392);
    load(0, 3, 200);
    load(1, 5, 77);
    load(2, 3, -1);
    load(3, 0, 999);
    load(3, 3, -5000);
    for (int i = 0; i < 10; i++) begin
      acc = '0;
      acc[tv[i].lane*DW +: DW] = tv[i].acc;
      send(acc, tv[i].grp, tv[i].en, 1'b1);
      wait_drain();
      o = obs[$];
      chk($sformatf("vec%0d_sat", i), W'(o.ds[tv[i].lane*DW +: DW]), W'(tv[i].es));
      chk($sformatf("vec%0d_wrap", i), W'(o.dw[tv[i].lane*DW +: DW]), W'(tv[i].ew));
      chk($sformatf("vec%0d_flag", i), W'(o.f[tv[i].lane]), W'(tv[i].ef));
      chk($sformatf("vec%0d_err", i), W'(o.e), W'(tv[i].ee));
    end
    // load racing an accept of the same group: old bias first, new bias next
    in_valid = 1; in_group = 1; in_bias_en = 1; in_acc = '0;
    ld_en = 1; ld_group = 1; ld_lane = 5; ld_data = DW'(500);
    @(posedge clk);
    #1 ld_en = 0;
    @(posedge clk);
    #1 in_valid = 0;
    wait_drain();
    chk("ldrace_old", W'(obs[obs.size()-2].ds[5*DW +: DW]), W'(77));
    chk("ldrace_new", W'(obs[obs.size()-1].ds[5*DW +: DW]), W'(500));
    // back-to-back stream under a stalling sink
    n0 = obs.size();
    busy = 1'b1;
    fork
      begin
        for (int v = 0; v < 8; v++) begin
          acc = rand_vec();
          acc[DW +: DW] = DW'(v + 1);
          send(acc, 2, 1'b0, v == 7);
        end
        busy = 1'b0;
      end
      begin
        for (int c = 0; busy; c++) begin
          out_ready = (c % 4 == 0) || (c % 4 == 3);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1;
    wait_drain();
    chk("b2b_count", W'(obs.size() - n0), W'(8));
    for (int v = 0; v < 8 && n0 + v < obs.size(); v++)
      chk($sformatf("b2b_order%0d", v), W'(obs[n0+v].ds[DW +: DW]), W'(v + 1));
    // randomized traffic, loads and backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom);
      in_acc = rand_vec();
      in_group = 2'($urandom_range(0, 3));
      in_bias_en = ($urandom % 4) != 0;
      ld_en = ($urandom % 3) == 0;
      ld_group = 2'($urandom_range(0, 3));
      ld_lane = 4'($urandom);
      ld_data = DW'($urandom);
      out_ready = ($urandom % 3) != 0;
      @(posedge clk);
      #1;
    end
    in_valid = 0; ld_en = 0; out_ready = 1;
    wait_drain();
    // reset with both stages full
    out_ready = 0;
    send(rand_vec(), 0, 1'b1, 1'b0);
    send(rand_vec(), 1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", W'({ov_s, ov_w}), W'(0));
    chk("midrst_ready", W'({rdy_s, rdy_w}), W'(2'b11));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1;
    for (int g = 0; g < DEP; g++) begin
      acc = rand_vec();
      send(acc, g, 1'b1, 1'b1);
      wait_drain();
      chk($sformatf("postrst_g%0d_sat", g), obs[$].ds, acc);
      chk($sformatf("postrst_g%0d_wrap", g), obs[$].dw, acc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
